subsystem_dpadder: RTL and testbench

SUBSYSTEM_DPADDER -- requirements
Module: subsystem_dpadder

---
 rtl/subsystem_dpadder.sv | 100 ++++++++++
 tb/tb_subsystem_dpadder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/subsystem_dpadder.sv
`default_nettype none
// ============================================================================
// Module      : subsystem_dpadder
// Description : Registered data pointer with a per-cycle +1 / -1 / hold
//               step command. It provides a combinational look-ahead of the
//               next value, a registered zero flag and a registered
//               one-cycle boundary-crossing pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH       : pointer width in bits (default 16)
//   RESET_VALUE : value loaded into dp while reset is asserted (default 0)
// Ports
//   CLK     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-high reset
//   dp_inc  in   2      0 = hold, 1 = +1, 2 = -1, 3 = hold (reserved)
//   dp      out  WIDTH  registered pointer
//   dp_next out  WIDTH  value dp takes at the next rising edge
//   dp_zero out  1      registered, high while dp == 0
//   dp_wrap out  1      registered pulse after a boundary-crossing step
// Build option
//   DPADDER_SATURATE_EN : when defined, the pointer clamps at all-ones and
//                         at zero instead of wrapping. dp_wrap still pulses
//                         on every clamped attempt.
// ============================================================================
module subsystem_dpadder #(
    parameter int unsigned           WIDTH       = 16,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [1:0]       dp_inc,
    output logic [WIDTH-1:0] dp,
    output logic [WIDTH-1:0] dp_next,
    output logic             dp_zero,
    output logic             dp_wrap
);

    localparam logic [WIDTH-1:0] c_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]       c_INC   = 2'd1;
    localparam logic [1:0]       c_DEC   = 2'd2;

    logic [WIDTH-1:0] r_dp;
    logic             r_zero;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next;
    logic             w_cross;

    // Next-value computation. w_cross flags a step that would leave the
    // unsigned range. It is the same condition for wrap and for saturate
    // builds; only the resulting value differs.
    always_comb begin
        w_next  = r_dp;
        w_cross = 1'b0;
        case (dp_inc)
            c_INC: begin
                w_cross = (r_dp == '1);
`ifdef DPADDER_SATURATE_EN
                w_next  = w_cross ? r_dp : (r_dp + c_ONE);
`else
                w_next  = r_dp + c_ONE;
`endif
            end
            c_DEC: begin
                w_cross = (r_dp == '0);
`ifdef DPADDER_SATURATE_EN
                w_next  = w_cross ? r_dp : (r_dp - c_ONE);
`else
                w_next  = r_dp - c_ONE;
`endif
            end
            default: begin
                w_next  = r_dp;
                w_cross = 1'b0;
            end
        endcase
    end

    // The zero flag is computed from the next value, so it is registered in
    // the same edge as the pointer and never lags it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_dp   <= RESET_VALUE;
            r_zero <= (RESET_VALUE == '0);
            r_wrap <= 1'b0;
        end else begin
            r_dp   <= w_next;
            r_zero <= (w_next == '0);
            r_wrap <= w_cross;
        end
    end

    assign dp      = r_dp;
    assign dp_next = w_next;
    assign dp_zero = r_zero;
    assign dp_wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_subsystem_dpadder.sv
`default_nettype none
// ============================================================================
// Module      : tb_subsystem_dpadder
// Description : Directed self-checking bench for subsystem_dpadder with
//               WIDTH = 16 and RESET_VALUE = 0. Expectations follow the
//               DPADDER_SATURATE_EN build option when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subsystem_dpadder;

    logic        CLK;
    logic        reset;
    logic [1:0]  dp_inc;
    logic [15:0] dp;
    logic [15:0] dp_next;
    logic        dp_zero;
    logic        dp_wrap;

    int checks;
    int errors;

    subsystem_dpadder #(
        .WIDTH       (16),
        .RESET_VALUE (16'h0000)
    ) u_dut (
        .CLK     (CLK),
        .reset   (reset),
        .dp_inc  (dp_inc),
        .dp      (dp),
        .dp_next (dp_next),
        .dp_zero (dp_zero),
        .dp_wrap (dp_wrap)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        dp_inc = 2'd0;

        // Asynchronous reset, taking effect before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk16("rst_dp",   dp, 16'h0000);
        chk1 ("rst_zero", dp_zero, 1'b1);
        chk1 ("rst_wrap", dp_wrap, 1'b0);

        // dp_inc is ignored while reset is held.
        dp_inc = 2'd1;
        edges(2);
        chk16("rst_ignore_inc", dp, 16'h0000);

        // +1 for two cycles -> 2
        reset  = 1'b0;
        dp_inc = 2'd1;
        edges(2);
        dp_inc = 2'd0;
        chk16("inc2_dp",   dp, 16'h0002);
        chk1 ("inc2_zero", dp_zero, 1'b0);
        #1;
        chk16("hold_next", dp_next, 16'h0002);

        // -1 once -> 1, then +1 twice -> 3
        dp_inc = 2'd2;
        edges(1);
        chk16("dec1_dp", dp, 16'h0001);
        dp_inc = 2'd1;
        edges(2);
        chk16("inc_to3_dp", dp, 16'h0003);

        // Hold with 0 and with reserved 3, then -1 twice -> 1
        dp_inc = 2'd0;
        edges(2);
        chk16("hold0_dp", dp, 16'h0003);
        dp_inc = 2'd3;
        edges(2);
        chk16("hold3_dp", dp, 16'h0003);
        dp_inc = 2'd2;
        edges(2);
        chk16("dec2_dp", dp, 16'h0001);

        // Down to zero without any crossing
        edges(1);
        dp_inc = 2'd0;
        chk16("at0_dp",   dp, 16'h0000);
        chk1 ("at0_zero", dp_zero, 1'b1);
        chk1 ("at0_wrap", dp_wrap, 1'b0);

        // Decrement at zero
        dp_inc = 2'd2;
        #1;
`ifdef DPADDER_SATURATE_EN
        chk16("under_next", dp_next, 16'h0000);
        edges(1);
        dp_inc = 2'd0;
        chk16("under_dp",   dp, 16'h0000);
        chk1 ("under_zero", dp_zero, 1'b1);
`else
        chk16("under_next", dp_next, 16'hFFFF);
        edges(1);
        dp_inc = 2'd0;
        chk16("under_dp",   dp, 16'hFFFF);
        chk1 ("under_zero", dp_zero, 1'b0);
`endif
        chk1 ("under_wrap", dp_wrap, 1'b1);
        edges(1);
        chk1 ("under_wrap_clear", dp_wrap, 1'b0);

`ifndef DPADDER_SATURATE_EN
        // Increment at all-ones -> 0
        dp_inc = 2'd1;
        edges(1);
        dp_inc = 2'd0;
        chk16("over_dp",   dp, 16'h0000);
        chk1 ("over_zero", dp_zero, 1'b1);
        chk1 ("over_wrap", dp_wrap, 1'b1);
        edges(1);
        chk1 ("over_wrap_clear", dp_wrap, 1'b0);

        // Back-to-back crossings keep dp_wrap high
        dp_inc = 2'd2;
        edges(1);
        dp_inc = 2'd1;
        chk16("b2b_dp1",   dp, 16'hFFFF);
        chk1 ("b2b_wrap1", dp_wrap, 1'b1);
        edges(1);
        dp_inc = 2'd0;
        chk16("b2b_dp2",   dp, 16'h0000);
        chk1 ("b2b_wrap2", dp_wrap, 1'b1);
`else
        // Increment clamps at all-ones: climb down from zero is blocked, so
        // use a repeated decrement-at-zero to show a pulse on each attempt.
        dp_inc = 2'd2;
        edges(2);
        dp_inc = 2'd0;
        chk16("sat_rep_dp",   dp, 16'h0000);
        chk1 ("sat_rep_wrap", dp_wrap, 1'b1);
`endif

        // Count to 5, then reset mid-cycle with an increment pending.
        edges(1);
        dp_inc = 2'd1;
        edges(5);
        chk16("to5_dp", dp, 16'h0005);
        #2 reset = 1'b1;
        #1;
        chk16("midrst_dp",   dp, 16'h0000);
        chk1 ("midrst_zero", dp_zero, 1'b1);
        chk1 ("midrst_wrap", dp_wrap, 1'b0);
        edges(2);
        chk16("midrst_hold_dp", dp, 16'h0000);

        // Counting resumes on the first edge after release.
        reset = 1'b0;
        edges(1);
        dp_inc = 2'd0;
        chk16("resume_dp",   dp, 16'h0001);
        chk1 ("resume_zero", dp_zero, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
